// File: rtl/prio_arb_pkg.sv
// prio_arb_pkg: shared types and limits for the priority arbiter.
//   state_t : arbiter FSM states (IDLE, GRANT)
//   MAX_N   : largest supported requester count
package prio_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int unsigned MAX_N = 64;

endpackage : prio_arb_pkg

// File: rtl/prio_pick.sv
// prio_pick: combinational winner selection for the arbiter.
//   req     : request levels, bit i = requester i
//   ptr     : round-robin start position
//   rr_en   : 1 = round-robin scan from ptr, 0 = highest index wins
//   win_idx : selected requester (0 when no request is set)
//   any_req : at least one request bit is set
module prio_pick
  import prio_arb_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             rr_en,
  output logic [IDX_W-1:0] win_idx,
  output logic             any_req
);

  always_comb begin
    int unsigned pos;
    logic        found;
    win_idx = '0;
    any_req = |req;
    found   = 1'b0;
    pos     = 0;
    if (rr_en) begin
      // Ascending scan starting at ptr; pos never exceeds N-1 after the wrap.
      for (int unsigned i = 0; i < N; i++) begin
        pos = 32'(ptr) + i;
        if (pos >= N) pos = pos - N;
        if (!found && req[pos[IDX_W-1:0]]) begin
          win_idx = pos[IDX_W-1:0];
          found   = 1'b1;
        end
      end
    end else begin
      // Later iterations overwrite earlier ones, so the highest index wins.
      for (int unsigned i = 0; i < N; i++) begin
        if (req[i]) win_idx = IDX_W'(i);
      end
    end
  end

endmodule : prio_pick

// File: rtl/priority_arbiter.sv
// priority_arbiter: registered N-way arbiter with grant/ack handshake.
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   req        : request levels, bit i = requester i
//   rr_en      : 1 = round-robin, 0 = fixed priority (sampled at arbitration)
//   ack        : grant owner completion pulse (ignored while idle)
//   gnt_valid  : a grant is active
//   gnt_idx    : binary index of the granted requester
//   gnt_onehot : one-hot of gnt_idx, zero when no grant
// The grant is held until ack; on ack the arbiter re-arbitrates in the same
// cycle so back-to-back grants have no bubble.
module priority_arbiter
  import prio_arb_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             rr_en,
  input  logic             ack,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N-1:0]     gnt_onehot
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     onehot_q, onehot_d;

  logic [IDX_W-1:0] win_idx;
  logic             any_req;

  prio_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .rr_en   (rr_en),
    .win_idx (win_idx),
    .any_req (any_req)
  );

  always_comb begin
    logic latch;
    logic clear;
    state_d  = state_q;
    ptr_d    = ptr_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    latch    = 1'b0;
    clear    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_req) latch = 1'b1;
      end
      GRANT: begin
        if (ack) begin
          if (any_req) latch = 1'b1;
          else         clear = 1'b1;
        end
      end
      default: clear = 1'b1;
    endcase

    if (latch) begin
      state_d           = GRANT;
      valid_d           = 1'b1;
      idx_d             = win_idx;
      onehot_d          = '0;
      onehot_d[win_idx] = 1'b1;
      // ptr follows every grant in both modes so round-robin resumes fairly.
      ptr_d = (win_idx == IDX_W'(N - 1)) ? '0 : win_idx + 1'b1;
    end else if (clear) begin
      state_d  = IDLE;
      valid_d  = 1'b0;
      idx_d    = '0;
      onehot_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
    end
  end

  assign gnt_valid  = valid_q;
  assign gnt_idx    = idx_q;
  assign gnt_onehot = onehot_q;

endmodule : priority_arbiter

// File: doc/priority_arbiter.md
# priority_arbiter

Parametrised, registered N-way request arbiter with a grant/acknowledge handshake. It selects one requester by either fixed priority (highest index wins) or round-robin, then holds the grant until the owner acknowledges completion. The arbiter sits in front of shared resources such as a bus port or a single-issue unit. It supersedes the combinational 4-input priority encoder for any path that needs fairness, more inputs, or a grant that stays stable across cycles.

## Interface
Parameters:
- N, default 8: number of requesters; legal range is 2 to 64.
- IDX_W, default $clog2(N): width of the grant index (derived; do not override).

Ports:
- clk  input  1  the single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  per-requester request levels; bit i = requester i.
- rr_en  input  1  mode select: 1 = round-robin, 0 = fixed priority.
- ack  input  1  the current grant owner signals completion; single-cycle pulse.
- gnt_valid  output  1  a grant is active.
- gnt_idx  output  IDX_W  binary index of the granted requester.
- gnt_onehot  output  N  one-hot form of gnt_idx; all zeros when gnt_valid=0.

## Operation
- FSM with two states, IDLE and GRANT. Reset state is IDLE.
- All outputs are registered. Reset values: gnt_valid=0, gnt_idx=0, gnt_onehot=0. Round-robin pointer ptr=0.
- IDLE:
  - If req is nonzero, latch the winner and move to GRANT.
  - If req is zero, stay in IDLE with outputs at their reset values.
- GRANT:
  - Outputs are frozen until ack=1. Changes to req, including the owner dropping its request, do not affect them.
  - On ack with req nonzero: arbitrate again in the same cycle and stay in GRANT. The new index appears next cycle and gnt_valid stays 1.
  - On ack with req zero: go to IDLE and clear the outputs.
- Winner selection:
  - Fixed priority (rr_en=0): the highest set index of req wins.
  - Round-robin (rr_en=1): scan ascending from ptr, wrapping at N-1 to 0. The first set bit wins.
- ptr update:
  - On every latched grant to index k, ptr becomes (k+1) mod N.
  - ptr is updated in both modes, so switching into round-robin continues fairly from the last grant.
  - Wrap-around: when k=N-1, ptr becomes 0.
- Re-arbitration on ack uses the current req, including the owner's request if it is still high. In fixed mode the same requester may therefore win again.
- rr_en is sampled only at arbitration. A change during GRANT takes effect at the next arbitration.
- ack outside GRANT is ignored.
- Asserting rst_n low clears state, ptr and outputs immediately, with no clock required, even mid-grant.

## Timing
- Latency from request to grant: req sampled at edge t gives gnt_valid=1 after edge t, i.e. 1 cycle.
- Handover: ack=1 at edge t gives the new gnt_idx visible after edge t. There are no bubble cycles between back-to-back grants.
- Release: ack=1 at edge t with req=0 gives gnt_valid=0 after edge t.
- Minimum grant duration is 1 cycle: ack may be asserted in the first cycle gnt_valid=1.
- There is no combinational path from req, rr_en or ack to any output.

## Structure
- Package prio_arb_pkg holds:
  - the state enum typedef state_t {IDLE, GRANT};
  - the localparam constant MAX_N = 64.
- Sub-module prio_pick is purely combinational.
  - Inputs: req, ptr, rr_en.
  - Outputs: win_idx and any_req.
  - It contains both selection schemes; the parent holds the FSM, ptr and output registers.

## Test plan
All scenarios use N=8.
1. Reset: rst_n=0 with req=8'hFF, then released with req=0 → gnt_valid=0, gnt_idx=0, gnt_onehot=0 for 5 cycles.
2. Fixed priority with hold:
   - rr_en=0, req=8'b0010_0110 → one cycle later gnt_idx=5, gnt_onehot=8'h20, gnt_valid=1.
   - Then req=8'h01 with ack=0 for 10 cycles → grant unchanged.
3. Round-robin sweep: rr_en=1, req=8'hFF, ack=1 every cycle → gnt_idx sequence 0,1,2,…,7,0,1 with gnt_valid continuously 1.
4. Round-robin wrap: after a grant to 5 (ptr=6), ack with req=8'b0000_0011 → next gnt_idx=0, and ptr becomes 1.
5. Release: in GRANT, ack=1 with req=0 → next cycle gnt_valid=0, gnt_onehot=0. A stray ack=1 while IDLE produces no change.
6. Reset mid-grant: drop rst_n asynchronously between edges during GRANT (gnt_idx=3) → outputs go to 0 before the next edge. After release, rr_en=1 with req=8'h88 → grant 3, confirming ptr was reset to 0.
